dm_ctrl: RTL

DM_CTRL -- requirements
Module: dm_ctrl

---
 rtl/dm_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/dm_ctrl.sv
// Word-organised data memory with byte/half/word stores and sign/zero-extended loads.
// Stores are read-modify-write on the clock edge; loads are combinational from current contents.
module dm_ctrl #(
  parameter int DEPTH = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Pc,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        MemWrite,
  input  logic [1:0]  StoreType,
  input  logic [2:0]  LoadType,
  output logic [31:0] RData,
  output logic        AddrErr
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_W = 2'b00, ST_H = 2'b01, ST_B = 2'b10, ST_RSV = 2'b11} st_e;
  typedef enum logic [2:0] {LD_W = 3'b000, LD_H = 3'b001, LD_HU = 3'b010,
                            LD_B = 3'b011, LD_BU = 3'b100} ld_e;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          misalign;
  logic [31:0]   rword;
  logic [15:0]   rhalf;
  logic [7:0]    rbyte;
  logic [3:0]    be;
  logic [31:0]   wpat;
  logic [31:0]   merged;
  logic          we;

  assign idx      = Addr[AW+1:2];
  assign in_range = {2'b00, Addr[31:2]} < 32'(DEPTH);
  assign rword    = in_range ? mem[idx] : 32'h0;
  assign rhalf    = Addr[1] ? rword[31:16] : rword[15:0];
  assign rbyte    = rword[8*Addr[1:0] +: 8];

  // Alignment is judged by the store width on a store cycle, else by the load width.
  always_comb begin
    misalign = 1'b0;
    if (MemWrite) begin
      case (st_e'(StoreType))
        ST_W:    misalign = Addr[1:0] != 2'b00;
        ST_H:    misalign = Addr[0];
        default: misalign = 1'b0;
      endcase
    end else begin
      case (ld_e'(LoadType))
        LD_H, LD_HU: misalign = Addr[0];
        LD_B, LD_BU: misalign = 1'b0;
        default:     misalign = Addr[1:0] != 2'b00;
      endcase
    end
  end

  assign AddrErr = !in_range || misalign;

  always_comb begin
    RData = 32'h0;
    if (!AddrErr) begin
      case (ld_e'(LoadType))
        LD_H:    RData = {{16{rhalf[15]}}, rhalf};
        LD_HU:   RData = {16'h0, rhalf};
        LD_B:    RData = {{24{rbyte[7]}}, rbyte};
        LD_BU:   RData = {24'h0, rbyte};
        default: RData = rword;
      endcase
    end
  end

  always_comb begin
    be   = 4'b0000;
    wpat = WData;
    case (st_e'(StoreType))
      ST_W: be = 4'b1111;
      ST_H: begin
        be   = Addr[1] ? 4'b1100 : 4'b0011;
        wpat = {2{WData[15:0]}};
      end
      ST_B: begin
        be   = 4'b0001 << Addr[1:0];
        wpat = {4{WData[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    merged = rword;
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = wpat[8*b +: 8];
  end

  assign we = MemWrite && !reset && !AddrErr && (StoreType != ST_RSV);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (we) begin
      mem[idx] <= merged;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (we) $display("%0t@%h: *%h <= %h", $time, Pc, {Addr[31:2], 2'b00}, merged);
  end
`endif

endmodule
